video_timing_ctrl: RTL and testbench

Video timing controller for the ray-tracer display path. It generates the raster counters and the `vo_hsync` / `vo_vsync` / `vo_blank_` strobes. It sequences the ray-tracer line producer with a one-line-ahead request/ready handshake and flags lines that were not delivered in time. It sits between the pixel clock domain and the scanline buffer feeding `vo_r/g/b`.

---
 rtl/video_timing_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster timing generator for the ray-tracer display path.
// Produces hsync/vsync/blank strobes and visible pixel coordinates, and runs a
// one-line-ahead request/ready handshake with the line producer, flagging any
// line that was not delivered before its predecessor finished scanning out.
// Optional build macro VTC_UNDERFLOW_CNT_EN adds a saturating 16-bit
// underflow_cnt output; without it only the sticky underflow flag exists.
module video_timing_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   output logic        vo_hsync,
   output logic        vo_vsync,
   output logic        vo_blank_,
   output logic [15:0] pix_x,
   output logic [15:0] pix_y,
   output logic        frame_start,
   output logic        line_req_valid,
   output logic [15:0] line_req_y,
   input  logic        line_req_ready,
   output logic        underflow
`ifdef VTC_UNDERFLOW_CNT_EN
   ,
   output logic [15:0] underflow_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [15:0] H_ACT_L    = 16'(H_ACTIVE);
   localparam logic [15:0] H_SYNC_BEG = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] H_SYNC_END = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_ACT_L    = 16'(V_ACTIVE);
   localparam logic [15:0] V_SYNC_BEG = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] V_SYNC_END = 16'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);

   // Counters are 16 bits wide, so the totals must fit.
   if (H_TOTAL > 65535) begin : g_h_total_check
      $error("video_timing_ctrl: H_TOTAL must not exceed 65535");
   end
   if (V_TOTAL > 65535) begin : g_v_total_check
      $error("video_timing_ctrl: V_TOTAL must not exceed 65535");
   end

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } req_state_t;

   req_state_t  state;
   logic [15:0] h_cnt;
   logic [15:0] v_cnt;
   logic [15:0] v_inc;
   logic [15:0] next_line;
   logic        next_vis;
   logic        h_last;
   logic        v_last;
   logic        visible;
   logic        hsync_act;
   logic        vsync_act;
   logic        req_start;
   logic        req_expire;

   // Decode the current raster position and work out which line comes next.
   always_comb begin
      v_inc      = v_cnt + 16'd1;
      h_last     = (h_cnt == H_LAST);
      v_last     = (v_cnt == V_LAST);
      visible    = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
      hsync_act  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
      vsync_act  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
      next_vis   = 1'b0;
      next_line  = 16'd0;
      if (v_inc < V_ACT_L) begin
         next_vis  = 1'b1;
         next_line = v_inc;
      end else if (v_last) begin
         next_vis  = 1'b1;
         next_line = 16'd0;
      end
      req_start  = (h_cnt == H_ACT_L) && next_vis;
      req_expire = (state == REQ) && !line_req_ready && h_last;
   end

   // Raster counters; disabling parks them at the origin so a restart begins a fresh frame.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= 16'd0;
         v_cnt <= 16'd0;
      end else if (!enable) begin
         h_cnt <= 16'd0;
         v_cnt <= 16'd0;
      end else if (h_last) begin
         h_cnt <= 16'd0;
         v_cnt <= v_last ? 16'd0 : v_inc;
      end else begin
         h_cnt <= h_cnt + 16'd1;
      end
   end

   // Registered video strobes and coordinates, one cycle behind the counters.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vo_hsync    <= !SYNC_POL;
         vo_vsync    <= !SYNC_POL;
         vo_blank_   <= 1'b0;
         pix_x       <= 16'd0;
         pix_y       <= 16'd0;
         frame_start <= 1'b0;
      end else if (!enable) begin
         vo_hsync    <= !SYNC_POL;
         vo_vsync    <= !SYNC_POL;
         vo_blank_   <= 1'b0;
         pix_x       <= 16'd0;
         pix_y       <= 16'd0;
         frame_start <= 1'b0;
      end else begin
         vo_hsync    <= hsync_act ? SYNC_POL : !SYNC_POL;
         vo_vsync    <= vsync_act ? SYNC_POL : !SYNC_POL;
         vo_blank_   <= visible;
         pix_x       <= visible ? h_cnt : 16'd0;
         pix_y       <= visible ? v_cnt : 16'd0;
         frame_start <= (h_cnt == 16'd0) && (v_cnt == 16'd0);
      end
   end

   // Line request FSM: ask for the next visible line at end of active video, expire at end of line.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         line_req_valid <= 1'b0;
         line_req_y     <= 16'd0;
         underflow      <= 1'b0;
      end else if (!enable) begin
         state          <= IDLE;
         line_req_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_start) begin
                  state          <= REQ;
                  line_req_valid <= 1'b1;
                  line_req_y     <= next_line;
               end
            end
            REQ: begin
               if (line_req_ready) begin
                  line_req_valid <= 1'b0;
                  state          <= h_last ? IDLE : DONE;
               end else if (h_last) begin
                  line_req_valid <= 1'b0;
                  underflow      <= 1'b1;
                  state          <= IDLE;
               end
            end
            DONE: begin
               if (h_last) begin
                  state <= IDLE;
               end
            end
            default: begin
               state          <= IDLE;
               line_req_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef VTC_UNDERFLOW_CNT_EN
   // Saturating count of expired line requests.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         underflow_cnt <= 16'd0;
      end else if (enable && req_expire && (underflow_cnt != 16'hFFFF)) begin
         underflow_cnt <= underflow_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl: directed bench for video_timing_ctrl on a 14x7 raster.
// Expected frame_start cycles and line handshakes are queued by the stimulus
// and popped by an independent negedge monitor; static outputs are checked
// against hand-derived raster positions. Honours VTC_UNDERFLOW_CNT_EN.
module tb_video_timing_ctrl;

   localparam int HT = 14;
   localparam int VT = 7;
   localparam int FRAME = HT * VT;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        line_req_ready;
   logic        vo_hsync;
   logic        vo_vsync;
   logic        vo_blank_;
   logic [15:0] pix_x;
   logic [15:0] pix_y;
   logic        frame_start;
   logic        line_req_valid;
   logic [15:0] line_req_y;
   logic        underflow;
`ifdef VTC_UNDERFLOW_CNT_EN
   logic [15:0] underflow_cnt;
`endif

   typedef struct {
      int          cyc;
      logic [15:0] y;
   } req_t;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   fs_q[$];
   req_t req_q[$];

   video_timing_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b0)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .enable(enable),
      .vo_hsync(vo_hsync),
      .vo_vsync(vo_vsync),
      .vo_blank_(vo_blank_),
      .pix_x(pix_x),
      .pix_y(pix_y),
      .frame_start(frame_start),
      .line_req_valid(line_req_valid),
      .line_req_y(line_req_y),
      .line_req_ready(line_req_ready),
      .underflow(underflow)
`ifdef VTC_UNDERFLOW_CNT_EN
      ,
      .underflow_cnt(underflow_cnt)
`endif
   );

   // Free-running pixel clock.
   always #5 clock = ~clock;

   // Cycle stamp used to time events.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic rdy);
      enable         = en;
      line_req_ready = rdy;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_hsync"}, vo_hsync, 1);
      checkOutput({tag, "_vsync"}, vo_vsync, 1);
      checkOutput({tag, "_blank"}, vo_blank_, 0);
      checkOutput({tag, "_pix_x"}, pix_x, 0);
      checkOutput({tag, "_pix_y"}, pix_y, 0);
      checkOutput({tag, "_valid"}, line_req_valid, 0);
   endtask

   // Monitor: pop and compare queued frame_start and handshake events as the DUT presents them.
   always @(negedge clock) begin
      if (reset_n) begin
         if (frame_start === 1'b1) begin
            if (fs_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_frame_start: got pulse at cycle %0d expected none", cyc);
            end else begin
               checkOutput("frame_start_cycle", cyc, fs_q.pop_front());
            end
         end
         if (line_req_valid === 1'b1 && line_req_ready === 1'b1) begin
            if (req_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_handshake: got y=%0d at cycle %0d expected none", line_req_y, cyc);
            end else begin
               req_t e;
               e = req_q.pop_front();
               checkOutput("handshake_cycle", cyc, e.cyc);
               checkOutput("handshake_y", line_req_y, e.y);
            end
         end
      end
   end

   // Directed scenarios.
   initial begin
      int   c0;
      int   h;
      int   v;
      logic vis;
      int   blank_errs, pix_errs, hs_errs, vs_errs;
      int   vis_cnt, hs_cnt, vs_cnt, vs_rise;
      logic vs_prev;
      int   uf_errs, valid_cnt;
      req_t r;

      reset_n = 1'b0;
      applyStimulus(1'b0, 1'b0);
      repeat (3) @(negedge clock);
      checkIdle("reset");
      checkOutput("reset_frame_start", frame_start, 0);
      checkOutput("reset_line_req_y", line_req_y, 0);
      checkOutput("reset_underflow", underflow, 0);
`ifdef VTC_UNDERFLOW_CNT_EN
      checkOutput("reset_underflow_cnt", underflow_cnt, 0);
`endif
      @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (50) @(negedge clock);
      checkIdle("disabled");
      checkOutput("disabled_line_req_y", line_req_y, 0);
      checkOutput("disabled_underflow", underflow, 0);

      // Raster and handshake: ready tied high for two frames.
      applyStimulus(1'b1, 1'b1);
      c0 = cyc + 1;
      for (int f = 0; f < 2; f++) begin
         fs_q.push_back(c0 + f * FRAME);
         for (int l = 0; l < 3; l++) begin
            r.cyc = c0 + f * FRAME + l * HT + 8;
            r.y   = 16'(l + 1);
            req_q.push_back(r);
         end
         r.cyc = c0 + f * FRAME + 6 * HT + 8;
         r.y   = 16'd0;
         req_q.push_back(r);
      end
      blank_errs = 0; pix_errs = 0; hs_errs = 0; vs_errs = 0;
      vis_cnt = 0; hs_cnt = 0; vs_cnt = 0; vs_rise = 0; vs_prev = 1'b1;
      for (int j = 0; j < 2 * FRAME; j++) begin
         @(negedge clock);
         h   = j % HT;
         v   = (j / HT) % VT;
         vis = (h < 8) && (v < 4);
         if (vo_blank_ !== vis) blank_errs++;
         if (pix_x !== (vis ? 16'(h) : 16'd0)) pix_errs++;
         if (pix_y !== (vis ? 16'(v) : 16'd0)) pix_errs++;
         if (vo_hsync !== ((h == 10 || h == 11) ? 1'b0 : 1'b1)) hs_errs++;
         if (vo_vsync !== ((v == 5) ? 1'b0 : 1'b1)) vs_errs++;
         if (vo_blank_ === 1'b1) vis_cnt++;
         if (vo_hsync === 1'b0) hs_cnt++;
         if (vo_vsync === 1'b0) vs_cnt++;
         if (vs_prev === 1'b1 && vo_vsync === 1'b0) vs_rise++;
         vs_prev = vo_vsync;
      end
      checkOutput("raster_blank_pattern_errs", blank_errs, 0);
      checkOutput("raster_pix_pattern_errs", pix_errs, 0);
      checkOutput("raster_hsync_pattern_errs", hs_errs, 0);
      checkOutput("raster_vsync_pattern_errs", vs_errs, 0);
      checkOutput("raster_visible_cycles", vis_cnt, 64);
      checkOutput("raster_hsync_cycles", hs_cnt, 28);
      checkOutput("raster_vsync_cycles", vs_cnt, 28);
      checkOutput("raster_vsync_starts", vs_rise, 2);
      checkOutput("raster_underflow", underflow, 0);
      applyStimulus(1'b0, 1'b1);
      repeat (3) @(negedge clock);
      checkIdle("raster_stop");

      // Late ready: producer answers only three cycles before line end.
      applyStimulus(1'b1, 1'b0);
      c0 = cyc + 1;
      fs_q.push_back(c0);
      r.cyc = c0 + 9;  r.y = 16'd1; req_q.push_back(r);
      r.cyc = c0 + 23; r.y = 16'd2; req_q.push_back(r);
      for (int j = 0; j < 2 * HT; j++) begin
         @(negedge clock);
         if (j == 8 || j == 9) begin
            checkOutput("late_valid_line1", line_req_valid, 1);
            checkOutput("late_y_line1", line_req_y, 1);
         end
         if (j == 22 || j == 23) begin
            checkOutput("late_valid_line2", line_req_valid, 1);
            checkOutput("late_y_line2", line_req_y, 2);
         end
         if (j == 10) checkOutput("late_valid_after_hs", line_req_valid, 0);
         if (j == 8 || j == 22) begin
            @(posedge clock);
            #1 line_req_ready = 1'b1;
         end else if (j == 9 || j == 23) begin
            @(posedge clock);
            #1 line_req_ready = 1'b0;
         end
      end
      checkOutput("late_underflow", underflow, 0);
      applyStimulus(1'b0, 1'b0);
      repeat (3) @(negedge clock);

      // Abort: drop enable at v=2,h=5 for three cycles, then restart.
      applyStimulus(1'b1, 1'b1);
      c0 = cyc + 1;
      fs_q.push_back(c0);
      r.cyc = c0 + 8;  r.y = 16'd1; req_q.push_back(r);
      r.cyc = c0 + 22; r.y = 16'd2; req_q.push_back(r);
      repeat (2 * HT + 5) @(negedge clock);
      applyStimulus(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checkIdle("abort");
      end
      applyStimulus(1'b1, 1'b1);
      c0 = cyc + 1;
      fs_q.push_back(c0);
      r.cyc = c0 + 8; r.y = 16'd1; req_q.push_back(r);
      @(negedge clock);
      checkOutput("restart_frame_start", frame_start, 1);
      checkOutput("restart_blank", vo_blank_, 1);
      checkOutput("restart_pix_x", pix_x, 0);
      checkOutput("restart_pix_y", pix_y, 0);
      repeat (HT - 1) @(negedge clock);
      applyStimulus(1'b0, 1'b1);
      repeat (3) @(negedge clock);

      // Underflow: ready tied low for two frames and a bit.
      applyStimulus(1'b1, 1'b0);
      c0 = cyc + 1;
      fs_q.push_back(c0);
      fs_q.push_back(c0 + FRAME);
      fs_q.push_back(c0 + 2 * FRAME);
      uf_errs = 0;
      valid_cnt = 0;
      for (int j = 0; j < 2 * FRAME + 10; j++) begin
         @(negedge clock);
         if (j == 12) checkOutput("underflow_before_expiry", underflow, 0);
         if (j >= 13 && underflow !== 1'b1) uf_errs++;
         if (j < 2 * FRAME && line_req_valid === 1'b1) valid_cnt++;
`ifdef VTC_UNDERFLOW_CNT_EN
         if (j == 13) checkOutput("underflow_cnt_first", underflow_cnt, 1);
         if (j == 2 * FRAME - 1) checkOutput("underflow_cnt_two_frames", underflow_cnt, 8);
`endif
      end
      checkOutput("underflow_sticky_errs", uf_errs, 0);
      checkOutput("underflow_valid_cycles", valid_cnt, 40);
      checkOutput("underflow_valid_pending", line_req_valid, 1);
      applyStimulus(1'b0, 1'b0);
      @(negedge clock);
      checkOutput("enable_drop_valid", line_req_valid, 0);
      checkOutput("enable_drop_underflow_held", underflow, 1);

      // Reset asserted mid-request clears valid without waiting for a clock edge.
      applyStimulus(1'b1, 1'b0);
      c0 = cyc + 1;
      fs_q.push_back(c0);
      repeat (10) @(negedge clock);
      checkOutput("midreq_valid", line_req_valid, 1);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("async_reset_valid", line_req_valid, 0);
      checkOutput("async_reset_underflow", underflow, 0);
      checkOutput("async_reset_hsync", vo_hsync, 1);
`ifdef VTC_UNDERFLOW_CNT_EN
      checkOutput("async_reset_underflow_cnt", underflow_cnt, 0);
`endif
      applyStimulus(1'b0, 1'b0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (3) @(negedge clock);

      checkOutput("frame_start_events_left", fs_q.size(), 0);
      checkOutput("handshake_events_left", req_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
